// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned WIDTH_N_DEF = 16;
  localparam int unsigned WIDTH_D_DEF = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH_D = WIDTH_D_DEF
) (
  input  logic [WIDTH_D:0]   rem,
  input  logic               bit_in,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D:0]   rem_next,
  output logic               q_bit
);

  logic [WIDTH_D+1:0] shifted;
  logic [WIDTH_D+1:0] diff;

  // The full remainder takes part in the shift; its top bit is always zero
  // because the remainder stays below the divisor, so the sign of the
  // difference at WIDTH_D+2 bits is the trial result.
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[WIDTH_D+1];
    rem_next = q_bit ? diff[WIDTH_D:0] : shifted[WIDTH_D:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH_N = WIDTH_N_DEF,
  parameter int unsigned WIDTH_D = WIDTH_D_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int unsigned CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  logic [1:0]         state;
  logic [WIDTH_N-1:0] shreg;
  logic [WIDTH_D-1:0] dvsr;
  logic [WIDTH_D:0]   rem;
  logic [CW-1:0]      cnt;
  logic [WIDTH_D:0]   rem_next;
  logic               q_bit;

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .rem      (rem),
    .bit_in   (shreg[WIDTH_N-1]),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // FSM, iteration counter, shift/remainder registers and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      dvsr        <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg <= dividend;
            dvsr  <= divisor;
            rem   <= '0;
            cnt   <= CW'(WIDTH_N - 1);
            busy  <= 1'b1;
            state <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          shreg <= {shreg[WIDTH_N-2:0], q_bit};
          rem   <= rem_next;
          if (cnt == '0) begin
            quotient    <= {shreg[WIDTH_N-2:0], q_bit};
            remainder   <= rem_next[WIDTH_D-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // busy still set here means we came straight from IDLE with a zero
          // divisor: publish the fixed result now and spend one more cycle in
          // DONE so the done pulse follows the same one-cycle rule.
          if (busy) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results computed
// with plain / and %, a monitor pops and compares on every done pulse.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  exp_t sbq[$];

  seq_divider #(
    .WIDTH_N (16),
    .WIDTH_D (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = 8'd0; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = 8'(a % b); e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with no pending request (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", t < 50, 1);
  endtask

  // inject > 0: pulse an extra start at that cycle of the run (must be ignored)
  // inject < 0: raise start during the done cycle (must be ignored)
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input int inject);
    exp_t e;
    int   lat;
    @(negedge clk);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e = model(a, b);
    sbq.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == inject) begin
        start = 1'b1; dividend = 16'd99; divisor = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", lat, (b == 0) ? 1 : 16);
    check("busy_low_at_done", busy, 0);
    if (inject < 0) begin
      start = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom) | 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("quotient_hold", quotient, e.q);
    check("remainder_hold", remainder, e.r);
    if (inject < 0) check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    int t;
    int t_prev;
    int r;
    logic [15:0] a;
    logic [7:0]  b;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);

    // Directed cases
    do_div(16'd100, 8'd7, 0);
    do_div(16'd65535, 8'd1, 0);
    do_div(16'd65535, 8'd255, 0);
    do_div(16'd0, 8'd13, 0);
    do_div(16'd200, 8'd201, 0);
    do_div(16'd1234, 8'd0, 0);
    do_div(16'd1234, 8'd2, 0);
    do_div(16'd50, 8'd5, 5);
    do_div(16'd1000, 8'd3, -1);
    do_div(16'd77, 8'd0, -1);

    // start held high: back-to-back results every 18 cycles
    @(negedge clk);
    wait_idle();
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    repeat (3) sbq.push_back(model(16'd1000, 8'd7));
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      @(negedge clk);
      while (!done && t < 40) begin
        @(negedge clk);
        t++;
      end
      check("b2b_done_seen", done, 1);
      if (k > 0) check("b2b_interval", cyc - t_prev, 18);
      t_prev = cyc;
      if (k == 2) start = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check("b2b_stopped", busy, 0);

    // Reset in the middle of a run aborts it without a done
    dividend = 16'd40000;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_resume", busy, 0);
    do_div(16'd40000, 8'd3, 0);

    // Randomized operands, with extremes mixed in
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      a = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
      b = (r == 2) ? 8'd0 : (r == 3) ? 8'hFF : (r == 4) ? 8'd1 : 8'($urandom_range(1, 255));
      do_div(a, b, (r > 6) ? int'($urandom_range(2, 14)) : 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
